event_arbiter: RTL and testbench

Round-robin scheduler that shares one event filter datapath between several event sources. Each source presents a 2-bit x/y/t/p event with a level request. The arbiter grants one source and latches its event. It presents the event to the filter, held stable for a fixed window long enough for the filter's polarity-stability check. It then inserts an idle gap so the filter returns to its idle state before the next event. The block sits between the sensor-side source interfaces and the event filter input.

---
 rtl/event_arbiter.sv | 123 ++++++++++++
 tb/tb_event_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_arbiter.sv
// Round-robin arbiter that shares one event filter between NUM_SRC sources.
// Each grant latches a 2-bit x/y/t/p event, holds it for HOLD_CYCLES, then idles GAP_CYCLES.
module event_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 6,
    parameter int GAP_CYCLES  = 1,
    localparam int IDW        = $clog2(NUM_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [2*NUM_SRC-1:0]   src_x,
    input  logic [2*NUM_SRC-1:0]   src_y,
    input  logic [2*NUM_SRC-1:0]   src_t,
    input  logic [2*NUM_SRC-1:0]   src_p,
    output logic [NUM_SRC-1:0]     ack,
    output logic [1:0]             f_x,
    output logic [1:0]             f_y,
    output logic [1:0]             f_t,
    output logic [1:0]             f_p,
    output logic                   f_valid,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy,
    output logic [7:0]             served_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [3:0]       hold_cnt;
    logic [1:0]       gap_cnt;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   next_ptr;

    // Scan downward so the lowest offset from ptr is the one that sticks.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_SRC]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'((int'(ptr) + k) % NUM_SRC);
            end
        end
    end

    assign next_ptr = (pick_idx == IDW'(NUM_SRC - 1)) ? '0 : pick_idx + 1'b1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            ack        <= '0;
            f_x        <= '0;
            f_y        <= '0;
            f_t        <= '0;
            f_p        <= '0;
            f_valid    <= 1'b0;
            grant_id   <= '0;
            served_cnt <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        f_x      <= src_x[2*int'(pick_idx) +: 2];
                        f_y      <= src_y[2*int'(pick_idx) +: 2];
                        f_t      <= src_t[2*int'(pick_idx) +: 2];
                        f_p      <= src_p[2*int'(pick_idx) +: 2];
                        f_valid  <= 1'b1;
                        ack      <= NUM_SRC'(1) << pick_idx;
                        grant_id <= pick_idx;
                        ptr      <= next_ptr;
                        hold_cnt <= 4'(HOLD_CYCLES - 1);
                        if (served_cnt != 8'hFF) begin
                            served_cnt <= served_cnt + 8'd1;
                        end
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        f_x     <= '0;
                        f_y     <= '0;
                        f_t     <= '0;
                        f_p     <= '0;
                        f_valid <= 1'b0;
                        gap_cnt <= 2'(GAP_CYCLES - 1);
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 2'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end
                default: begin
                    f_x     <= '0;
                    f_y     <= '0;
                    f_t     <= '0;
                    f_p     <= '0;
                    f_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: timeline-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_event_arbiter;

    localparam int N = 4;
    localparam int H = 6;
    localparam int G = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] src_x, src_y, src_t, src_p;
    logic [N-1:0]   ack;
    logic [1:0]     f_x, f_y, f_t, f_p;
    logic           f_valid;
    logic [1:0]     grant_id;
    logic           busy;
    logic [7:0]     served_cnt;

    event_arbiter #(.NUM_SRC(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .req(req),
        .src_x(src_x), .src_y(src_y), .src_t(src_t), .src_p(src_p),
        .ack(ack), .f_x(f_x), .f_y(f_y), .f_t(f_t), .f_p(f_p),
        .f_valid(f_valid), .grant_id(grant_id), .busy(busy), .served_cnt(served_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the edge of the last grant and derives every output
    // from its distance to the current cycle.
    int         edge_n = 0;
    bit         model_ok = 0;
    bit         has_g;
    int         last_g;
    int         free_at;
    int         m_ptr, m_served, m_id;
    logic [1:0] m_fx, m_fy, m_ft, m_fp;
    int         now_c, idx, sel;
    bit         found;
    logic [N-1:0] e_ack;
    logic         e_valid, e_busy;
    logic [1:0]   e_fx, e_fy, e_ft, e_fp;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            model_ok = 1;
            m_ptr = 0; m_served = 0; m_id = 0; has_g = 0;
            m_fx = 0; m_fy = 0; m_ft = 0; m_fp = 0;
            free_at = edge_n + 1;
        end else if (model_ok && edge_n >= free_at && req != 0) begin
            found = 0;
            sel = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found = 1;
                    sel = idx;
                end
            end
            m_fx = src_x[2*sel +: 2];
            m_fy = src_y[2*sel +: 2];
            m_ft = src_t[2*sel +: 2];
            m_fp = src_p[2*sel +: 2];
            m_id = sel;
            m_ptr = (sel + 1) % N;
            if (m_served < 255) m_served++;
            has_g = 1;
            last_g = edge_n;
            free_at = edge_n + H + G + 1;
        end
        now_c   = edge_n + 1;
        e_valid = has_g && (now_c <= last_g + H);
        e_busy  = has_g && (now_c <= last_g + H + G);
        e_ack   = (has_g && now_c == last_g + 1) ? N'(1 << m_id) : '0;
        e_fx    = e_valid ? m_fx : 2'd0;
        e_fy    = e_valid ? m_fy : 2'd0;
        e_ft    = e_valid ? m_ft : 2'd0;
        e_fp    = e_valid ? m_fp : 2'd0;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("ack",        32'(ack),        32'(e_ack));
            checkOutput("f_valid",    32'(f_valid),    32'(e_valid));
            checkOutput("busy",       32'(busy),       32'(e_busy));
            checkOutput("f_x",        32'(f_x),        32'(e_fx));
            checkOutput("f_y",        32'(f_y),        32'(e_fy));
            checkOutput("f_t",        32'(f_t),        32'(e_ft));
            checkOutput("f_p",        32'(f_p),        32'(e_fp));
            checkOutput("grant_id",   32'(grant_id),   32'(m_id));
            checkOutput("served_cnt", 32'(served_cnt), 32'(m_served));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] r, input bit do_rst);
        req = r;
        rst = do_rst;
        @(negedge clk);
    endtask

    task automatic waitAck(output logic [N-1:0] a, output int cyc);
        bit seen = 0;
        a = '0;
        cyc = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                seen = 1;
                a = ack;
                cyc = edge_n;
            end
        end
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [N-1:0] a;
    int           c, prev_c, cnt;
    int           rr_exp [5] = '{1, 2, 4, 8, 1};

    initial begin
        req = '0; src_x = '0; src_y = '0; src_t = '0; src_p = '0;
        rst = 1'b1;

        // Reset held for two cycles with every source requesting.
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ack",     32'(ack),        32'd0);
        checkOutput("rst_valid",   32'(f_valid),    32'd0);
        checkOutput("rst_busy",    32'(busy),       32'd0);
        checkOutput("rst_served",  32'(served_cnt), 32'd0);
        checkOutput("rst_grant",   32'(grant_id),   32'd0);
        rst = 1'b0;
        waitAck(a, c);
        checkOutput("first_grant", 32'(a), 32'd1);
        req = '0;
        waitIdle();

        // Single source on index 2.
        src_x[5:4] = 2'd3; src_y[5:4] = 2'd1; src_t[5:4] = 2'd2; src_p[5:4] = 2'd1;
        req = 4'b0100;
        waitAck(a, c);
        req = '0;
        checkOutput("single_ack",   32'(a),        32'd4);
        checkOutput("single_fx",    32'(f_x),      32'd3);
        checkOutput("single_fy",    32'(f_y),      32'd1);
        checkOutput("single_ft",    32'(f_t),      32'd2);
        checkOutput("single_fp",    32'(f_p),      32'd1);
        checkOutput("single_grant", 32'(grant_id), 32'd2);
        cnt = 0;
        for (int i = 0; i < 20 && f_valid; i++) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("hold_len",  32'(cnt),  32'd6);
        checkOutput("gap_busy",  32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("gap_end",   32'(busy), 32'd0);

        // Round-robin with all sources requesting, starting from a fresh pointer.
        applyStimulus(4'b1111, 1'b1);
        rst = 1'b0;
        prev_c = 0;
        for (int i = 0; i < 5; i++) begin
            waitAck(a, c);
            checkOutput("rr_order", 32'(a), 32'(rr_exp[i]));
            if (i > 0) checkOutput("rr_spacing", 32'(c - prev_c), 32'd8);
            prev_c = c;
        end
        req = '0;
        waitIdle();

        // Changes during HOLD: fields of the granted source and other requests move.
        applyStimulus(4'b0000, 1'b1);
        rst = 1'b0;
        src_x[1:0] = 2'd2; src_y[1:0] = 2'd3; src_t[1:0] = 2'd1; src_p[1:0] = 2'd0;
        req = 4'b0001;
        waitAck(a, c);
        req = 4'b1110;
        src_x[1:0] = 2'd1; src_y[1:0] = 2'd0; src_t[1:0] = 2'd3; src_p[1:0] = 2'd2;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        checkOutput("frozen_fx", 32'(f_x), 32'd2);
        checkOutput("frozen_fy", 32'(f_y), 32'd3);
        checkOutput("frozen_ft", 32'(f_t), 32'd1);
        checkOutput("frozen_fp", 32'(f_p), 32'd0);
        waitAck(a, c);
        checkOutput("dropped_skip", 32'(a), 32'd4);

        // Reset in the third hold cycle.
        req = 4'b1000;
        waitIdle();
        waitAck(a, c);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid",  32'(f_valid),    32'd0);
        checkOutput("midrst_busy",   32'(busy),       32'd0);
        checkOutput("midrst_served", 32'(served_cnt), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        waitAck(a, c);
        checkOutput("midrst_ptr", 32'(a), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            src_x = 8'($urandom); src_y = 8'($urandom);
            src_t = 8'($urandom); src_p = 8'($urandom);
            applyStimulus(N'($urandom), ($urandom_range(0, 199) == 0));
        end
        rst = 1'b0;

        // Saturation of the served counter.
        applyStimulus(4'b1111, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 260; i++) waitAck(a, c);
        checkOutput("sat_served", 32'(served_cnt), 32'd255);
        repeat (10) @(negedge clk);
        checkOutput("sat_hold", 32'(served_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
